pc_exception_unit: RTL and testbench
====================================

Name: pc_exception_unit

Overview:
- Program-counter register stage directly downstream of the PC-source mux in the multicycle MIPS datapath.
- Latches the mux output into PC under unconditional or branch-conditional write enables.
- Owns EPC and the exception cause code.
- Runs the exception-entry sequence: save EPC, fetch the handler byte from the fixed memory vector over a req/ack handshake, load it into PC. Stalls the control unit via busy while the sequence runs.

Parameters:
- RESET_PC, 32'd0: PC value on reset.
- VEC_OPCODE, 32'd253: memory address holding the handler address for an invalid opcode.
- VEC_OVF, 32'd254: memory address holding the handler address for an arithmetic overflow.
- VEC_DIV0, 32'd255: memory address holding the handler address for divide by zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- next_pc  in  32  candidate PC from the PC-source mux.
- pc_write  in  1  unconditional PC write enable.
- pc_write_cond  in  1  conditional PC write enable (branch).
- branch_ne  in  1  0 = beq (taken when alu_zero=1); 1 = bne (taken when alu_zero=0).
- alu_zero  in  1  ALU zero flag.
- exc_opcode  in  1  invalid-opcode exception request, one-cycle pulse or level.
- exc_ovf  in  1  overflow exception request.
- exc_div0  in  1  divide-by-zero exception request.
- exc_mem_ack  in  1  memory has valid data for the outstanding vector read.
- exc_mem_data  in  32  memory read data; only bits [7:0] are used.
- pc  out  32  current program counter.
- epc  out  32  exception program counter.
- cause  out  2  00 none, 01 opcode, 10 overflow, 11 div0.
- exc_mem_req  out  1  vector read request.
- exc_mem_addr  out  32  vector read address.
- busy  out  1  high while the exception sequence is active; control unit must hold.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, epc=0, cause=00, exc_mem_req=0, exc_mem_addr=0, busy=0, state=IDLE.
  - Reset asserted mid-sequence aborts the sequence immediately; req drops in the same instant.
- All outputs are registered except busy, which is decoded from state (busy = state != IDLE).
- State IDLE, no exception input high:
  - pc_en = pc_write | (pc_write_cond & (alu_zero ^ branch_ne)).
  - If pc_en=1, pc <= next_pc on the next edge. Write latency is one edge.
  - pc_write and pc_write_cond both high: treated as an OR (write).
- State IDLE, any exception input high:
  - Exception entry takes precedence; any PC write that cycle is discarded.
  - epc <= pc - 4, modulo 2^32 (pc=0 gives FFFFFFFC), because fetch has already incremented PC.
  - Priority when several are high: opcode > overflow > div0. cause and exc_mem_addr are set to the winner's code and vector.
  - exc_mem_req <= 1; state -> REQ.
- State REQ:
  - exc_mem_req held at 1 and exc_mem_addr stable until ack; no timeout.
  - When exc_mem_ack=1 at an edge: pc <= {24'b0, exc_mem_data[7:0]}, exc_mem_req <= 0, state -> IDLE. busy falls in the same cycle that req falls.
  - Ack is allowed in the first REQ cycle, giving a minimum sequence of 2 edges (entry edge plus ack edge).
  - pc_write, pc_write_cond and new exception inputs are ignored in REQ; they are not queued.
- exc_mem_ack while IDLE: ignored.
- cause and epc hold their values until the next exception entry or reset; normal PC writes never change them.
- exc_mem_addr holds the last vector after the sequence completes.

Test Plan:
- Reset then release, no enables: pc=0, epc=0, cause=00, busy=0. Assert pc_write with next_pc=0x00000004: pc=0x00000004 after 1 edge.
- Branch: pc_write_cond=1, branch_ne=0, alu_zero=1, next_pc=0x40 -> pc=0x40. Same with alu_zero=0 -> pc unchanged. branch_ne=1 with alu_zero=0 -> pc=0x40.
- Overflow with pc=0x1C: epc=0x18, cause=10, req=1, addr=254, busy=1. Ack after 3 cycles with data=0xABCD0080: pc=0x80, req=0, busy=0.
- Simultaneous exc_opcode, exc_div0 and pc_write: cause=01, addr=253, PC write discarded. exc_ovf pulsed during REQ: no change to cause or epc.
- Wrap: exception at pc=0 -> epc=0xFFFFFFFC. Ack in the first REQ cycle -> sequence completes in 2 edges.
- reset pulled low while in REQ: req=0, busy=0, pc=RESET_PC immediately. After release, no ack-driven PC load occurs.

Source files
------------

// File: rtl/pc_exception_unit.sv
// PC register stage with EPC/cause ownership and the exception-entry sequence
// (save EPC, read the handler byte from the fixed vector, load it into PC).
module pc_exception_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] VEC_DIV0   = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        branch_ne,
  input  logic        alu_zero,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic        exc_mem_ack,
  input  logic [31:0] exc_mem_data,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        exc_mem_req,
  output logic [31:0] exc_mem_addr,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        pc_en;
  logic        exc_any;
  logic        unused_data_hi;

  // Only the low byte of the vector word is a handler address.
  assign unused_data_hi = ^exc_mem_data[31:8];

  assign pc_en   = pc_write | (pc_write_cond & (alu_zero ^ branch_ne));
  assign exc_any = exc_opcode | exc_ovf | exc_div0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (exc_any) begin
          // fetch already advanced PC, so the faulting instruction sits 4 back
          epc_d   = pc_q - 32'd4;
          req_d   = 1'b1;
          state_d = S_REQ;
          if (exc_opcode) begin
            cause_d = 2'b01;
            addr_d  = VEC_OPCODE;
          end else if (exc_ovf) begin
            cause_d = 2'b10;
            addr_d  = VEC_OVF;
          end else begin
            cause_d = 2'b11;
            addr_d  = VEC_DIV0;
          end
        end else if (pc_en) begin
          pc_d = next_pc;
        end
      end
      S_REQ: begin
        if (exc_mem_ack) begin
          pc_d    = {24'b0, exc_mem_data[7:0]};
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      cause_q <= 2'b00;
      req_q   <= 1'b0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign cause        = cause_q;
  assign exc_mem_req  = req_q;
  assign exc_mem_addr = addr_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_pc_exception_unit.sv
// Directed and randomized bench for pc_exception_unit against a behavioural model.
module tb_pc_exception_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] next_pc = '0;
  logic        pc_write = 1'b0, pc_write_cond = 1'b0, branch_ne = 1'b0, alu_zero = 1'b0;
  logic        exc_opcode = 1'b0, exc_ovf = 1'b0, exc_div0 = 1'b0;
  logic        exc_mem_ack = 1'b0;
  logic [31:0] exc_mem_data = '0;
  logic [31:0] pc, epc, exc_mem_addr;
  logic [1:0]  cause;
  logic        exc_mem_req, busy;

  int n_pass = 0;
  int n_total = 0;

  pc_exception_unit dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .alu_zero(alu_zero),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .exc_mem_ack(exc_mem_ack), .exc_mem_data(exc_mem_data),
    .pc(pc), .epc(epc), .cause(cause), .exc_mem_req(exc_mem_req),
    .exc_mem_addr(exc_mem_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: "in_seq" means a vector read is outstanding.
  logic [31:0] m_pc, m_epc, m_addr;
  logic [1:0]  m_cause;
  logic        in_seq;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 32'd0; m_epc = 32'd0; m_cause = 2'd0; m_addr = 32'd0; in_seq = 1'b0;
    end else if (!in_seq) begin
      if (exc_opcode || exc_ovf || exc_div0) begin
        m_epc   = m_pc - 32'd4;
        m_cause = exc_opcode ? 2'd1 : (exc_ovf ? 2'd2 : 2'd3);
        m_addr  = 32'd252 + 32'(m_cause);
        in_seq  = 1'b1;
      end else if (pc_write || (pc_write_cond && (branch_ne ? !alu_zero : alu_zero))) begin
        m_pc = next_pc;
      end
    end else if (exc_mem_ack) begin
      m_pc   = exc_mem_data % 32'd256;
      in_seq = 1'b0;
    end
  end

  always @(posedge clk) begin
    #2;
    chk("m_pc",    pc,                  m_pc);
    chk("m_epc",   epc,                 m_epc);
    chk("m_cause", 32'(cause),          32'(m_cause));
    chk("m_req",   32'(exc_mem_req),    32'(in_seq));
    chk("m_addr",  exc_mem_addr,        m_addr);
    chk("m_busy",  32'(busy),           32'(in_seq));
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic clr();
    pc_write = 0; pc_write_cond = 0; branch_ne = 0; alu_zero = 0;
    exc_opcode = 0; exc_ovf = 0; exc_div0 = 0; exc_mem_ack = 0; exc_mem_data = 0;
  endtask

  initial begin
    #17 reset = 1'b1;
    cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", 32'(cause), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req", 32'(exc_mem_req), 32'h0);

    next_pc = 32'h4; pc_write = 1; cyc(); clr();
    chk("pc_write", pc, 32'h4);

    pc_write_cond = 1; alu_zero = 1; next_pc = 32'h40; cyc();
    chk("beq_taken", pc, 32'h40);
    alu_zero = 0; next_pc = 32'h80; cyc();
    chk("beq_not_taken", pc, 32'h40);
    branch_ne = 1; alu_zero = 0; next_pc = 32'h1C; cyc(); clr();
    chk("bne_taken", pc, 32'h1C);

    exc_ovf = 1; cyc(); clr();
    chk("ovf_epc", epc, 32'h18);
    chk("ovf_cause", 32'(cause), 32'h2);
    chk("ovf_req", 32'(exc_mem_req), 32'h1);
    chk("ovf_addr", exc_mem_addr, 32'd254);
    chk("ovf_busy", 32'(busy), 32'h1);
    cyc(); cyc(); cyc();
    chk("ovf_wait_req", 32'(exc_mem_req), 32'h1);
    exc_mem_ack = 1; exc_mem_data = 32'hABCD0080; cyc(); clr();
    chk("ovf_ack_pc", pc, 32'h80);
    chk("ovf_ack_req", 32'(exc_mem_req), 32'h0);
    chk("ovf_ack_busy", 32'(busy), 32'h0);

    exc_opcode = 1; exc_div0 = 1; pc_write = 1; next_pc = 32'h1234; cyc(); clr();
    chk("prio_cause", 32'(cause), 32'h1);
    chk("prio_addr", exc_mem_addr, 32'd253);
    chk("prio_pc_kept", pc, 32'h80);
    chk("prio_epc", epc, 32'h7C);
    exc_ovf = 1; pc_write = 1; next_pc = 32'h999; cyc(); clr();
    chk("req_ignore_cause", 32'(cause), 32'h1);
    chk("req_ignore_epc", epc, 32'h7C);
    chk("req_ignore_pc", pc, 32'h80);
    exc_mem_ack = 1; exc_mem_data = 32'h0; cyc(); clr();
    chk("to_zero_pc", pc, 32'h0);

    exc_div0 = 1; cyc(); clr();
    chk("wrap_epc", epc, 32'hFFFFFFFC);
    chk("wrap_cause", 32'(cause), 32'h3);
    exc_mem_ack = 1; exc_mem_data = 32'h11; cyc();
    chk("fast_ack_pc", pc, 32'h11);
    chk("fast_ack_busy", 32'(busy), 32'h0);
    exc_mem_data = 32'h55; cyc(); clr();
    chk("idle_ack_ignored", pc, 32'h11);
    chk("addr_held", exc_mem_addr, 32'd255);

    exc_opcode = 1; cyc(); clr();
    chk("pre_rst_busy", 32'(busy), 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("arst_req", 32'(exc_mem_req), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_pc", pc, 32'h0);
    exc_mem_ack = 1; exc_mem_data = 32'h99;
    cyc();
    #1 reset = 1'b1;
    cyc();
    chk("post_rst_no_load", pc, 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    clr();

    for (int i = 0; i < 3000; i++) begin
      next_pc       = $urandom;
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = ($urandom_range(0, 2) == 0);
      branch_ne     = $urandom_range(0, 1);
      alu_zero      = $urandom_range(0, 1);
      exc_opcode    = ($urandom_range(0, 19) == 0);
      exc_ovf       = ($urandom_range(0, 19) == 0);
      exc_div0      = ($urandom_range(0, 19) == 0);
      exc_mem_ack   = ($urandom_range(0, 2) == 0);
      exc_mem_data  = $urandom;
      if (i % 700 == 350) begin
        #1 reset = 1'b0;
        #2 reset = 1'b1;
      end
      cyc();
    end
    clr();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
